// File: rtl/controller_if.sv
// Bundles the opcode/pipeline-control inputs and the decoded ID/EX control outputs of the main decoder.
// The optional illegal_op output exists only when CONTROLLER_ILLEGAL_OP_EN is defined.
interface controller_if;
   logic [5:0] op;
   logic       stall;
   logic       flush;
   logic       memtoreg;
   logic       memwrite;
   logic       branch;
   logic       alusrc;
   logic       regdst;
   logic       regwrite;
   logic       jump;
   logic [3:0] aluop;
   logic       branchNot;
`ifdef CONTROLLER_ILLEGAL_OP_EN
   logic       illegal_op;
`endif

   modport master (
      output op, stall, flush,
      input  memtoreg, memwrite, branch, alusrc, regdst, regwrite, jump, aluop, branchNot
`ifdef CONTROLLER_ILLEGAL_OP_EN
      , input illegal_op
`endif
   );

   modport slave (
      input  op, stall, flush,
      output memtoreg, memwrite, branch, alusrc, regdst, regwrite, jump, aluop, branchNot
`ifdef CONTROLLER_ILLEGAL_OP_EN
      , output illegal_op
`endif
   );
endinterface

// File: rtl/controller.sv
// MIPS main decoder: opcode -> control word, registered at the ID/EX boundary with stall/flush.
// Define CONTROLLER_ILLEGAL_OP_EN to add a registered illegal_op flag for opcodes outside the table.
module controller (
   input logic        clk,
   input logic        reset_n,
   controller_if.slave bus
);

   typedef struct packed {
      logic       regwrite;
      logic       regdst;
      logic       alusrc;
      logic       branch;
      logic       branchNot;
      logic       memwrite;
      logic       memtoreg;
      logic       jump;
      logic [3:0] aluop;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_RTYP = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_SLT  = 4'b0100;
   localparam logic [3:0] ALU_SLTU = 4'b0101;
   localparam logic [3:0] ALU_LUI  = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_XOR  = 4'b1000;

   ctrl_t decCtrl;
   ctrl_t ctrl_d;
   ctrl_t ctrl_q;
`ifdef CONTROLLER_ILLEGAL_OP_EN
   logic  decIllegal;
   logic  illegal_d;
   logic  illegal_q;
`endif

   // Any opcode not in the table (including X/Z) falls to the NOP default.
   always_comb begin
      decCtrl = '0;
`ifdef CONTROLLER_ILLEGAL_OP_EN
      decIllegal = 1'b0;
`endif
      case (bus.op)
         OP_RTYPE: begin decCtrl.regwrite = 1'b1; decCtrl.regdst = 1'b1; decCtrl.aluop = ALU_RTYP; end
         OP_LW:    begin decCtrl.regwrite = 1'b1; decCtrl.alusrc = 1'b1; decCtrl.memtoreg = 1'b1; decCtrl.aluop = ALU_ADD; end
         OP_SW:    begin decCtrl.alusrc = 1'b1; decCtrl.memwrite = 1'b1; decCtrl.aluop = ALU_ADD; end
         OP_BEQ:   begin decCtrl.branch = 1'b1; decCtrl.aluop = ALU_SUB; end
         OP_BNE:   begin decCtrl.branchNot = 1'b1; decCtrl.aluop = ALU_SUB; end
         OP_ADDI:  begin decCtrl.regwrite = 1'b1; decCtrl.alusrc = 1'b1; decCtrl.aluop = ALU_ADD; end
         OP_ADDIU: begin decCtrl.regwrite = 1'b1; decCtrl.alusrc = 1'b1; decCtrl.aluop = ALU_ADD; end
         OP_SLTI:  begin decCtrl.regwrite = 1'b1; decCtrl.alusrc = 1'b1; decCtrl.aluop = ALU_SLT; end
         OP_SLTIU: begin decCtrl.regwrite = 1'b1; decCtrl.alusrc = 1'b1; decCtrl.aluop = ALU_SLTU; end
         OP_ANDI:  begin decCtrl.regwrite = 1'b1; decCtrl.alusrc = 1'b1; decCtrl.aluop = ALU_AND; end
         OP_ORI:   begin decCtrl.regwrite = 1'b1; decCtrl.alusrc = 1'b1; decCtrl.aluop = ALU_OR; end
         OP_XORI:  begin decCtrl.regwrite = 1'b1; decCtrl.alusrc = 1'b1; decCtrl.aluop = ALU_XOR; end
         OP_LUI:   begin decCtrl.regwrite = 1'b1; decCtrl.alusrc = 1'b1; decCtrl.aluop = ALU_LUI; end
         OP_J:     begin decCtrl.jump = 1'b1; decCtrl.aluop = ALU_ADD; end
         default: begin
            decCtrl = '0;
`ifdef CONTROLLER_ILLEGAL_OP_EN
            decIllegal = 1'b1;
`endif
         end
      endcase
   end

   // Flush beats stall; op is only looked at when neither is asserted.
   always_comb begin
      ctrl_d = ctrl_q;
`ifdef CONTROLLER_ILLEGAL_OP_EN
      illegal_d = illegal_q;
`endif
      if (bus.flush) begin
         ctrl_d = '0;
`ifdef CONTROLLER_ILLEGAL_OP_EN
         illegal_d = 1'b0;
`endif
      end else if (!bus.stall) begin
         ctrl_d = decCtrl;
`ifdef CONTROLLER_ILLEGAL_OP_EN
         illegal_d = decIllegal;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ctrl_q <= '0;
`ifdef CONTROLLER_ILLEGAL_OP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         ctrl_q <= ctrl_d;
`ifdef CONTROLLER_ILLEGAL_OP_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   assign bus.regwrite  = ctrl_q.regwrite;
   assign bus.regdst    = ctrl_q.regdst;
   assign bus.alusrc    = ctrl_q.alusrc;
   assign bus.branch    = ctrl_q.branch;
   assign bus.branchNot = ctrl_q.branchNot;
   assign bus.memwrite  = ctrl_q.memwrite;
   assign bus.memtoreg  = ctrl_q.memtoreg;
   assign bus.jump      = ctrl_q.jump;
   assign bus.aluop     = ctrl_q.aluop;
`ifdef CONTROLLER_ILLEGAL_OP_EN
   assign bus.illegal_op = illegal_q;
`endif

endmodule

// File: tb/tb_controller.sv
// Directed bench for the MIPS main decoder; expected words are {illegal, rw rd as br bn mw m2r j, aluop}.
module tb_controller;

   logic clk;
   logic reset_n;
   int   checkCount;
   int   errorCount;

   controller_if bus ();

   controller dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef CONTROLLER_ILLEGAL_OP_EN
   localparam logic ILL = 1'b1;
`else
   localparam logic ILL = 1'b0;
`endif

   function automatic logic [12:0] observed();
      logic illegalBit;
`ifdef CONTROLLER_ILLEGAL_OP_EN
      illegalBit = bus.illegal_op;
`else
      illegalBit = 1'b0;
`endif
      return {illegalBit, bus.regwrite, bus.regdst, bus.alusrc, bus.branch, bus.branchNot,
              bus.memwrite, bus.memtoreg, bus.jump, bus.aluop};
   endfunction

   task automatic checkOutput(input string tag, input logic [12:0] actual, input logic [12:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s actual=%b expected=%b", tag, actual, expected);
      end
   endtask

   // Apply one cycle of inputs, then sample #1 after the edge.
   task automatic applyStimulus(input logic [5:0] op, input logic stall, input logic flush);
      logic [12:0] obs;
      logic        bad;
      bus.op    = op;
      bus.stall = stall;
      bus.flush = flush;
      @(posedge clk);
      #1;
      obs = observed();
      bad = (obs[8] & obs[7]) | (obs[6] & obs[11]) | (obs[4] & (|{obs[11:5], obs[3]}));
      checkOutput("invariants", {12'b0, bad}, 13'b0);
   endtask

   logic [5:0]  opList  [14];
   logic [12:0] expList [14];

   initial begin
      checkCount = 0;
      errorCount = 0;
      opList[0]  = 6'b000000; expList[0]  = {1'b0, 8'b11000000, 4'b0010};
      opList[1]  = 6'b100011; expList[1]  = {1'b0, 8'b10100010, 4'b0000};
      opList[2]  = 6'b101011; expList[2]  = {1'b0, 8'b00100100, 4'b0000};
      opList[3]  = 6'b000100; expList[3]  = {1'b0, 8'b00010000, 4'b0001};
      opList[4]  = 6'b000101; expList[4]  = {1'b0, 8'b00001000, 4'b0001};
      opList[5]  = 6'b001000; expList[5]  = {1'b0, 8'b10100000, 4'b0000};
      opList[6]  = 6'b001001; expList[6]  = {1'b0, 8'b10100000, 4'b0000};
      opList[7]  = 6'b001010; expList[7]  = {1'b0, 8'b10100000, 4'b0100};
      opList[8]  = 6'b001011; expList[8]  = {1'b0, 8'b10100000, 4'b0101};
      opList[9]  = 6'b001100; expList[9]  = {1'b0, 8'b10100000, 4'b0111};
      opList[10] = 6'b001101; expList[10] = {1'b0, 8'b10100000, 4'b0011};
      opList[11] = 6'b001110; expList[11] = {1'b0, 8'b10100000, 4'b1000};
      opList[12] = 6'b001111; expList[12] = {1'b0, 8'b10100000, 4'b0110};
      opList[13] = 6'b000010; expList[13] = {1'b0, 8'b00000001, 4'b0000};

      reset_n = 1'b0;
      applyStimulus(6'b000000, 1'b0, 1'b0);
      checkOutput("reset1", observed(), 13'b0);
      applyStimulus(6'b000000, 1'b0, 1'b0);
      checkOutput("reset2", observed(), 13'b0);

      reset_n = 1'b1;
      applyStimulus(6'b000000, 1'b0, 1'b0);
      checkOutput("releaseRtype", observed(), {1'b0, 8'b11000000, 4'b0010});

      for (int i = 0; i < 14; i++) begin
         applyStimulus(opList[i], 1'b0, 1'b0);
         checkOutput($sformatf("sweep%0d", i), observed(), expList[i]);
      end

      applyStimulus(6'b100011, 1'b0, 1'b0);
      checkOutput("lwLoad", observed(), {1'b0, 8'b10100010, 4'b0000});
      applyStimulus(6'b101011, 1'b1, 1'b0);
      checkOutput("lwHeld", observed(), {1'b0, 8'b10100010, 4'b0000});
      applyStimulus(6'bxxxxxx, 1'b1, 1'b0);
      checkOutput("lwHeldXop", observed(), {1'b0, 8'b10100010, 4'b0000});
      applyStimulus(6'b101011, 1'b0, 1'b0);
      checkOutput("swAfterStall", observed(), {1'b0, 8'b00100100, 4'b0000});

      applyStimulus(6'b000100, 1'b1, 1'b1);
      checkOutput("flushWins", observed(), 13'b0);
      applyStimulus(6'b000101, 1'b0, 1'b0);
      checkOutput("bneAfterFlush", observed(), {1'b0, 8'b00001000, 4'b0001});
      applyStimulus(6'bxxxxxx, 1'b0, 1'b1);
      checkOutput("flushXop", observed(), 13'b0);

      applyStimulus(6'b111111, 1'b0, 1'b0);
      checkOutput("illegalOp", observed(), {ILL, 12'b0});
      applyStimulus(6'b001000, 1'b1, 1'b0);
      checkOutput("illegalHeld", observed(), {ILL, 12'b0});
      applyStimulus(6'b001000, 1'b0, 1'b0);
      checkOutput("illegalCleared", observed(), {1'b0, 8'b10100000, 4'b0000});
      applyStimulus(6'b010000, 1'b0, 1'b0);
      checkOutput("illegalOp2", observed(), {ILL, 12'b0});
      applyStimulus(6'b000010, 1'b0, 1'b1);
      checkOutput("flushClearsIllegal", observed(), 13'b0);

      applyStimulus(6'b000010, 1'b0, 1'b0);
      checkOutput("jump", observed(), {1'b0, 8'b00000001, 4'b0000});
      reset_n = 1'b0;
      applyStimulus(6'b100011, 1'b1, 1'b0);
      checkOutput("resetBeatsStall", observed(), 13'b0);
      reset_n = 1'b1;
      applyStimulus(6'b001111, 1'b0, 1'b0);
      checkOutput("luiAfterReset", observed(), {1'b0, 8'b10100000, 4'b0110});

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
